// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl : main control FSM of the multi-cycle RV32I subset core  |
// | Optional perf counters (instret_o, stall_cnt_o) under MC_PERF_CNT_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
    parameter int ACK_TIMEOUT = 16,
    parameter int TCNT_W      = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic [6:0]  opcode_i,
    input  logic        mem_ack_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        branch_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  imm_sel_o,
    output logic        busy_o,
    output logic        err_o,
`ifdef MC_PERF_CNT_EN
    output logic [31:0] instret_o,
    output logic [31:0] stall_cnt_o,
`endif
    output logic [1:0]  err_code_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_R      = 3'd1,
        C_I      = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5
    } cls_t;

    state_t             state, state_nx;
    cls_t               cls, cls_dec;
    logic [TCNT_W-1:0]  tcnt;
    logic [1:0]         err_code, trap_code;
    logic               trap, to_fetch, timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cls      <= C_NONE;
            tcnt     <= '0;
            err_code <= 2'b00;
        end else begin
            state <= state_nx;
            if (state == S_DECODE)
                cls <= cls_dec;
            if (trap)
                err_code <= trap_code;
            // Counter restarts on every state change, so it is zero on entry to FETCH/MEM.
            if (state_nx != state)
                tcnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !mem_ack_i)
                tcnt <= tcnt + TCNT_W'(1);
        end
    end

    always_comb begin
        cls_dec = C_NONE;
        case (opcode_i)
            7'b0110011: cls_dec = C_R;
            7'b0010011: cls_dec = C_I;
            7'b0000011: cls_dec = C_LOAD;
            7'b0100011: cls_dec = C_STORE;
            7'b1100011: cls_dec = C_BRANCH;
            default:    cls_dec = C_NONE;
        endcase
    end

    // The limit is hit on the ACK_TIMEOUT-th waiting cycle; an ack that same cycle wins.
    assign timeout = (tcnt == TCNT_W'(ACK_TIMEOUT - 1)) && !mem_ack_i;

    always_comb begin
        state_nx     = state;
        to_fetch     = 1'b0;
        trap         = 1'b0;
        trap_code    = 2'b00;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        branch_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = 2'b00;
        imm_sel_o    = 2'b00;
        case (state)
            S_IDLE: begin
                if (start_i)
                    to_fetch = 1'b1;
            end
            S_FETCH: begin
                mem_read_o = 1'b1;
                if (mem_ack_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_nx   = S_DECODE;
                end else if (timeout) begin
                    trap      = 1'b1;
                    trap_code = 2'b10;
                end
            end
            S_DECODE: begin
                if (cls_dec == C_NONE) begin
                    trap      = 1'b1;
                    trap_code = 2'b01;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_R: begin
                        alu_op_o = 2'b10;
                        state_nx = S_WB;
                    end
                    C_I: begin
                        alu_op_o  = 2'b10;
                        alu_src_o = 1'b1;
                        state_nx  = S_WB;
                    end
                    C_LOAD: begin
                        alu_src_o = 1'b1;
                        state_nx  = S_MEM;
                    end
                    C_STORE: begin
                        alu_src_o = 1'b1;
                        imm_sel_o = 2'b01;
                        state_nx  = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_op_o  = 2'b01;
                        imm_sel_o = 2'b10;
                        branch_o  = 1'b1;
                        to_fetch  = 1'b1;
                    end
                    default: begin
                        trap      = 1'b1;
                        trap_code = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                alu_src_o = 1'b1;
                if (cls == C_STORE) begin
                    mem_write_o = 1'b1;
                    imm_sel_o   = 2'b01;
                end else begin
                    mem_read_o = 1'b1;
                end
                if (mem_ack_i) begin
                    if (cls == C_STORE)
                        to_fetch = 1'b1;
                    else
                        state_nx = S_WB;
                end else if (timeout) begin
                    trap      = 1'b1;
                    trap_code = 2'b11;
                end
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (cls == C_LOAD);
                to_fetch     = 1'b1;
            end
            S_ERR: begin
                state_nx = S_ERR;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        // Halt is honoured only at an instruction boundary.
        if (to_fetch)
            state_nx = halt_i ? S_IDLE : S_FETCH;
        if (trap)
            state_nx = S_ERR;
    end

    assign busy_o     = (state != S_IDLE) && (state != S_ERR);
    assign err_o      = (state == S_ERR);
    assign err_code_o = err_code;

`ifdef MC_PERF_CNT_EN
    logic retire, stall;

    assign retire = (state == S_WB)
                 || (state == S_MEM  && cls == C_STORE && mem_ack_i)
                 || (state == S_EXEC && cls == C_BRANCH);
    assign stall  = (state == S_FETCH || state == S_MEM) && !mem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instret_o   <= 32'd0;
            stall_cnt_o <= 32'd0;
        end else begin
            if (retire)
                instret_o <= instret_o + 32'd1;
            if (stall)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
